// File: rtl/truth_table_checker_pkg.sv
// tt_check_pkg: shared state encoding and vector-count helper for truth_table_checker.
package tt_check_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_e;
  function automatic int num_vecs(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: start/response/status bundle between a tester and the checker.
interface truth_table_checker_if #(parameter int N_IN = 3, parameter int N_OUT = 2);
  logic              start;
  logic [N_OUT-1:0]  dut_out;
  logic [N_IN-1:0]   vec_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic              fail_valid;
  logic [N_IN-1:0]   first_fail_vec;
  modport master (output start, dut_out,
                  input vec_out, busy, done, pass, err_count, fail_valid, first_fail_vec);
  modport slave  (input start, dut_out,
                  output vec_out, busy, done, pass, err_count, fail_valid, first_fail_vec);
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: walks every input vector, samples the DUT and tallies mismatches.
// Define TT_CHECK_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module truth_table_checker import tt_check_pkg::*; #(
  parameter int N_IN = 3,
  parameter int N_OUT = 2,
  parameter int SETTLE = 1,
  parameter logic [num_vecs(N_IN)*N_OUT-1:0] EXPECTED = 16'hEAC0
) (
  input logic clk,
  input logic rst,
  truth_table_checker_if.slave bus
);
  localparam int NV = num_vecs(N_IN);
  localparam int CW = $clog2(SETTLE) + 1;
  localparam int IW = N_IN + 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fv_q, fv_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic [N_OUT-1:0] exp_w;
  logic miss, last, launch, stop;
  assign exp_w = EXPECTED[int'(idx_q[N_IN-1:0])*N_OUT +: N_OUT];
  assign miss = bus.dut_out != exp_w;
  assign last = idx_q == IW'(NV - 1);
  assign launch = bus.start && (state_q == IDLE || state_q == DONE);
`ifdef TT_CHECK_STOP_ON_FAIL_EN
  assign stop = miss;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    fv_d = fv_q;
    ffv_d = ffv_q;
    if (launch) begin
      state_d = APPLY;
      idx_d = '0;
      cnt_d = CW'(SETTLE - 1);
      err_d = '0;
      fv_d = 1'b0;
      ffv_d = '0;
    end else if (state_q == APPLY) begin
      state_d = cnt_q == '0 ? SAMPLE : APPLY;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
    end else if (state_q == SAMPLE) begin
      err_d = miss && !(&err_q) ? err_q + IW'(1) : err_q;
      fv_d = fv_q | miss;
      ffv_d = miss && !fv_q ? idx_q[N_IN-1:0] : ffv_q;
      // idx is left on the final (or failing) vector so vec_out holds it in DONE
      state_d = last || stop ? DONE : APPLY;
      idx_d = last || stop ? idx_q : idx_q + IW'(1);
      cnt_d = CW'(SETTLE - 1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      fv_q <= 1'b0;
      ffv_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      fv_q <= fv_d;
      ffv_q <= ffv_d;
    end
  end
  assign bus.vec_out = idx_q[N_IN-1:0];
  assign bus.busy = state_q == APPLY || state_q == SAMPLE;
  assign bus.done = state_q == DONE;
  assign bus.pass = state_q == DONE && err_q == '0;
  assign bus.err_count = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.first_fail_vec = ffv_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: randomized DUT faults scored against a spec-level reference model.
module tb_truth_table_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int md = 0;
  logic del = 1'b0;
  logic [15:0] mask = '0;
  logic [2:0] da1, da2, db1, db2;
  truth_table_checker_if #(.N_IN(3), .N_OUT(2)) ia();
  truth_table_checker_if #(.N_IN(3), .N_OUT(2)) ib();
  truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_out(input logic [2:0] v);
    logic o1;
    o1 = v[0] & v[1];
    return {o1 | v[2], o1};
  endfunction

  function automatic logic [1:0] dut_f(input logic [2:0] v, input int m, input logic [15:0] mk);
    logic [1:0] r;
    r = ref_out(v);
    if (m == 1) r[1] = 1'b0;
    if (m == 2) r = r ^ mk[2*v +: 2];
    return r;
  endfunction

  always @(posedge clk) begin
    da1 <= rst ? 3'd0 : ia.vec_out;
    da2 <= rst ? 3'd0 : da1;
    db1 <= rst ? 3'd0 : ib.vec_out;
    db2 <= rst ? 3'd0 : db1;
  end
  always_comb begin
    ia.dut_out = dut_f(del ? da2 : ia.vec_out, md, mask);
    ib.dut_out = dut_f(del ? db2 : ib.vec_out, md, mask);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int m, input logic [15:0] mk, output int e, output int fv, output int ff);
    e = 0; fv = 0; ff = 0;
    for (int v = 0; v < 8; v++) begin
      if (dut_f(3'(v), m, mk) != ref_out(3'(v))) begin
        e++;
        if (fv == 0) begin fv = 1; ff = v; end
`ifdef TT_CHECK_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  function automatic int run_len(input int fv, input int ff);
`ifdef TT_CHECK_STOP_ON_FAIL_EN
    if (fv != 0) return 2*ff + 3;
`endif
    return 17;
  endfunction

  task automatic run(input bit sel, input bit repulse, input bit walk, output int n);
    bit pulsed;
    pulsed = 0;
    @(negedge clk);
    if (sel) ib.start = 1'b1; else ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0; ib.start = 1'b0;
    n = 1;
    chk("clr_done", sel ? ib.done : ia.done, 0);
    chk("clr_err", sel ? ib.err_count : ia.err_count, 0);
    chk("clr_fv", sel ? ib.fail_valid : ia.fail_valid, 0);
    while (!(sel ? ib.done : ia.done) && n < 500) begin
      if (walk) chk("walk", ia.vec_out, (n - 1) / 2);
      if (repulse && !pulsed && ia.vec_out == 3'd4) begin ia.start = 1'b1; pulsed = 1; end
      @(posedge clk); #1;
      ia.start = 1'b0;
      n++;
    end
    chk("no_timeout", int'(n < 500), 1);
  endtask

  task automatic check_res(input bit sel, input int e, input int fv, input int ff);
    chk("done", sel ? ib.done : ia.done, 1);
    chk("busy", sel ? ib.busy : ia.busy, 0);
    chk("pass", sel ? ib.pass : ia.pass, int'(e == 0));
    chk("err_count", sel ? ib.err_count : ia.err_count, e);
    chk("fail_valid", sel ? ib.fail_valid : ia.fail_valid, fv);
    if (fv != 0) chk("first_fail", sel ? ib.first_fail_vec : ia.first_fail_vec, ff);
  endtask

  initial begin
    int n, e, fv, ff;
    ia.start = 1'b0;
    ib.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", ia.vec_out, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_pass", ia.pass, 0);
    chk("rst_err", ia.err_count, 0);
    chk("rst_fv", ia.fail_valid, 0);
    @(negedge clk) rst = 1'b0;

    md = 0;
    run(0, 0, 1, n);
    chk("cycles_ok", n, 17);
    check_res(0, 0, 0, 0);
    chk("last_vec", ia.vec_out, 7);

    md = 1;
    model(1, '0, e, fv, ff);
    run(0, 0, 0, n);
    chk("cycles_stuck", n, run_len(fv, ff));
    check_res(0, e, fv, ff);
`ifdef TT_CHECK_STOP_ON_FAIL_EN
    chk("stop_vec", ia.vec_out, ff);
`endif

    md = 0;
    run(0, 1, 0, n);
    chk("cycles_repulse", n, 17);
    check_res(0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      md = 2;
      mask = 16'($urandom);
      if (i == 0) mask = '0;
      model(2, mask, e, fv, ff);
      run(0, 0, 0, n);
      chk("cycles_rand", n, run_len(fv, ff));
      check_res(0, e, fv, ff);
    end

`ifdef TT_CHECK_STOP_ON_FAIL_EN
    md = 0;
`else
    md = 2;
    mask = 16'h000C;
`endif
    @(negedge clk) ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    n = 0;
    while (!(ia.vec_out == 3'd5 && ia.busy) && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_v5", int'(n < 100), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vec", ia.vec_out, 0);
    chk("arst_busy", ia.busy, 0);
    chk("arst_done", ia.done, 0);
    chk("arst_err", ia.err_count, 0);
    chk("arst_fv", ia.fail_valid, 0);
    chk("arst_ffv", ia.first_fail_vec, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", ia.busy, 0);
    chk("idle_done", ia.done, 0);
    md = 0;
    run(0, 0, 1, n);
    chk("cycles_after_rst", n, 17);
    check_res(0, 0, 0, 0);

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    md = 0;
    del = 1'b1;
    run(1, 0, 0, n);
    chk("cycles_settle3", n, 33);
    check_res(1, 0, 0, 0);
    run(0, 0, 0, n);
`ifdef TT_CHECK_STOP_ON_FAIL_EN
    chk("cycles_delay1", n, 9);
    check_res(0, 1, 1, 3);
`else
    chk("cycles_delay1", n, 17);
    check_res(0, 3, 1, 3);
`endif
    del = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Self-contained hardware response checker for small combinational DUTs.
- Steps through every input vector 0..2^N_IN-1 on vec_out and waits a settle interval after each one.
- Samples the DUT outputs on dut_out and compares them against a parameterised expected truth table.
- Reports pass/fail, a mismatch count and the first failing vector; sits between a DUT and a status register or LED bank.

Parameters:
- N_IN, 3, number of DUT inputs driven (1..8).
- N_OUT, 2, number of DUT outputs checked (1..8).
- SETTLE, 1, cycles a vector is held before sampling (>=1).
- EXPECTED, 16'hEAC0, flattened table; entry v = EXPECTED[v*N_OUT +: N_OUT]; default encodes out_1=in_1&in_2 (bit0), out_2=out_1|in_3 (bit1), with vec bit0=in_1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- dut_out  in  N_OUT  DUT response.
- vec_out  out  N_IN  vector driven to the DUT.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  done && err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors.
- fail_valid  out  1  first_fail_vec is meaningful.
- first_fail_vec  out  N_IN  index of the first mismatch.

Behaviour:
- Reset (async, any state): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, settle counter=0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: start=1 -> APPLY. On entry to APPLY: idx=0, settle counter=SETTLE-1, err_count=0, fail_valid=0.
- APPLY: vec_out=idx, busy=1. Settle counter decrements each cycle; at 0 -> SAMPLE.
- SAMPLE (one cycle): vec_out still =idx. Compare dut_out with EXPECTED entry idx.
  - Mismatch: err_count += 1, saturating at all-ones.
  - Mismatch with fail_valid=0: first_fail_vec=idx, fail_valid=1 (registered same edge).
- Leaving SAMPLE:
  - idx==2^N_IN-1 -> DONE.
  - Otherwise idx+1 -> APPLY with the settle counter reloaded.
- Timing: each vector takes SETTLE+1 cycles; done rises 2^N_IN*(SETTLE+1)+1 cycles after the start edge.
- DONE: busy=0, done=1, pass registered. vec_out holds the last vector.
  - start=1 -> APPLY, clearing done, pass, err_count and fail_valid on that edge.
- start while busy: ignored, no restart.
- Reset mid-run: immediate return to IDLE with all outputs at reset values; no partial result retained.
- dut_out is sampled only in SAMPLE; glitches during APPLY are ignored.
- Widths: idx is N_IN+1 bits internally so the last-vector compare does not wrap. vec_out is the low N_IN bits of idx. err_count max value 2^N_IN fits without saturation in normal use.

Optional Feature:
- Macro: TT_CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE.
  - err_count=1, fail_valid=1, pass=0.
  - vec_out holds the failing vector for debug.
- Undefined: the run always covers all 2^N_IN vectors.

Decomposition:
- Package tt_check_pkg holds:
  - state enum typedef (IDLE, APPLY, SAMPLE, DONE, 2-bit encoding).
  - localparam helper for the vector count (1<<N_IN).
- No sub-module: the settle counter and comparator are inline; the block is small enough as one module.

Test Plan:
- Correct DUT model (default EXPECTED), SETTLE=1, pulse start -> done=1 after 17 cycles, pass=1, err_count=0, fail_valid=0; vec_out walks 0..7.
- DUT model with out_2 stuck at 0 -> err_count=5 (vectors 3..7), first_fail_vec=3, fail_valid=1, pass=0.
- start re-pulsed at vector 4 while busy -> ignored; done after the original 17 cycles. A second start in DONE -> counters cleared, fresh run of 17 cycles.
- rst asserted asynchronously mid-APPLY at vector 5 -> all outputs 0 before the next clk edge; state IDLE; start afterwards runs from vector 0.
- SETTLE=3, DUT output delayed 2 cycles -> pass=1. Same DUT with SETTLE=1 -> mismatches reported.
- With TT_CHECK_STOP_ON_FAIL_EN, stuck-at DUT -> done at vector 3, err_count=1, vec_out=3, first_fail_vec=3.
